// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
//   rf_state_t   : clear-engine state (CLEAR while zeroing the array, RUN after)
//   DEF_*        : default widths used by regfile_mp
//   slice_field  : extract field k of width w from a packed multi-port bus
//                  (bus up to 256 bits, field up to 64 bits)
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  function automatic logic [63:0] slice_field(input logic [255:0] bus,
                                              input int k,
                                              input int w);
    logic [255:0] shifted;
    logic [63:0]  mask;
    shifted = bus >> (k * w);
    mask    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return shifted[63:0] & mask;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// regfile_bypass_mux: read-port output selection for one read port.
//   busy            : clear engine active -> output forced to 0
//   raddr           : read address of this port
//   stored          : array word at raddr
//   we0/waddr0/wdata0, we1/waddr1/wdata1 : write ports in flight this cycle
//   rdata           : selected read data
// Priority: busy / address 0 -> 0, then port 1 bypass, then port 0 bypass,
// then the stored word.
module regfile_bypass_mux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              busy,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] stored,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (busy || raddr == '0) begin
      rdata = '0;
    end else if (we1 && waddr1 == raddr) begin
      rdata = wdata1;
    end else if (we0 && waddr0 == raddr) begin
      rdata = wdata0;
    end else begin
      rdata = stored;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two write ports,
// NUM_RD (1..4) combinational read ports with write-to-read bypass, entry 0
// hardwired to zero, and a post-reset clear engine zeroing one entry/cycle.
//   clk, reset      : clock, synchronous active-high reset
//   we0/waddr0/wdata0/wpc0 : write port 0 (wpc0 used for trace only)
//   we1/waddr1/wdata1/wpc1 : write port 1, wins over port 0 on same address
//   raddr / rdata   : packed read ports, port k at [k*W +: W]
//   busy            : clear engine active (reads return 0, writes ignored)
//   wr_drop         : registered pulse, a user write was discarded
// Optional: define REGFILE_TRACE_EN to print one line per committed write.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic [31:0]              wpc0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [31:0]              wpc1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  rf_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] clr_idx_reg, clr_idx_next;
  logic              wr_drop_reg, wr_drop_next;

  logic w0_commit, w1_commit, same_addr;

  assign busy    = (state_reg == CLEAR);
  assign wr_drop = wr_drop_reg;

  assign same_addr = we0 && we1 && (waddr0 == waddr1);
  // Port 0 loses against port 1 on a shared address; address 0 never commits.
  assign w1_commit = !busy && we1 && (waddr1 != '0);
  assign w0_commit = !busy && we0 && (waddr0 != '0) && !same_addr;

  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    wr_drop_next = 1'b0;
    case (state_reg)
      CLEAR: begin
        // Wraps back to 0 exactly on the CLEAR->RUN transition.
        clr_idx_next = clr_idx_reg + 1'b1;
        if (clr_idx_reg == ADDR_W'(DEPTH - 1)) begin
          state_next = RUN;
        end
        wr_drop_next = we0 || we1;
      end
      RUN: begin
        // Same-address collision on address 0 is a silent discard, not a drop.
        wr_drop_next = same_addr && (waddr0 != '0);
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR;
      clr_idx_reg <= '0;
      wr_drop_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
      wr_drop_reg <= wr_drop_next;
    end
  end

  // Storage has no reset so it maps onto RAM; the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        mem[clr_idx_reg] <= '0;
      end else begin
        if (w0_commit) mem[waddr0] <= wdata0;
        if (w1_commit) mem[waddr1] <= wdata1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = ADDR_W'(slice_field(256'(raddr), gi, ADDR_W));

    regfile_bypass_mux #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_mux (
      .busy  (busy),
      .raddr (ra),
      .stored(mem[ra]),
      .we0   (we0),
      .waddr0(waddr0),
      .wdata0(wdata0),
      .we1   (we1),
      .waddr1(waddr1),
      .wdata1(wdata1),
      .rdata (rdata[gi*DATA_W +: DATA_W])
    );
  end

`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w0_commit) $display("%0t@%h: $%0d <= %h", $time, wpc0, waddr0, wdata0);
      if (w1_commit) $display("%0t@%h: $%0d <= %h", $time, wpc1, waddr1, wdata1);
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^{wpc0, wpc1};
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp (default params).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1, wpc0, wpc1;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic        busy, wr_drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk    (clk),
    .reset  (reset),
    .we0    (we0),
    .waddr0 (waddr0),
    .wdata0 (wdata0),
    .wpc0   (wpc0),
    .we1    (we1),
    .waddr1 (waddr1),
    .wdata1 (wdata1),
    .wpc1   (wpc1),
    .raddr  (raddr),
    .rdata  (rdata),
    .busy   (busy),
    .wr_drop(wr_drop)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        edrop;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0; wpc0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0; wpc1 = '0;
  endtask

  // Starts at a negedge with busy expected high; returns at the first negedge
  // where busy is low. Optionally injects writes that must be dropped.
  task automatic count_busy(input bit inject, output int cnt);
    cnt = 0;
    raddr = {5'd5, 5'd5};
    while (busy === 1'b1 && cnt < 100) begin
      if (inject && cnt == 3) begin
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h0000DEAD;
      end
      if (inject && cnt == 4) we0 = 1'b0;
      if (inject && cnt == 20) begin
        we1 = 1'b1; waddr1 = 5'd5; wdata1 = 32'h0000BEEF;
      end
      if (inject && cnt == 21) we1 = 1'b0;
      #1;
      check("busy_rdata_zero", rdata, 64'h0);
      if (inject && (cnt == 4 || cnt == 21)) check("busy_wr_drop_pulse", wr_drop, 1'b1);
      if (inject && cnt == 5) check("busy_wr_drop_cleared", wr_drop, 1'b0);
      cnt++;
      @(negedge clk);
    end
    $display("clear window: busy high for %0d cycles", cnt);
  endtask

  initial begin
    int cnt;

    vecs[0]  = '{1'b1, 5'd3,  32'h11111111, 1'b1, 5'd3,  32'h22222222, 5'd3,  5'd0,  32'h22222222, 32'h0,        1'b1};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h22222222, 32'h22222222, 1'b0};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd3,  32'h0,        32'h22222222, 1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd8,  32'h0,        32'h0,        1'b0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd8,  32'h88888888, 5'd8,  5'd3,  32'h88888888, 32'h22222222, 1'b0};
    vecs[5]  = '{1'b1, 5'd7,  32'hCAFEF00D, 1'b0, 5'd0,  32'h0,        5'd8,  5'd7,  32'h88888888, 32'hCAFEF00D, 1'b0};
    vecs[6]  = '{1'b1, 5'd9,  32'h00000099, 1'b1, 5'd10, 32'h000000AA, 5'd9,  5'd10, 32'h00000099, 32'h000000AA, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd9,  32'hCAFEF00D, 32'h00000099, 1'b0};
    vecs[8]  = '{1'b1, 5'd0,  32'h00005678, 1'b1, 5'd0,  32'h00001234, 5'd0,  5'd10, 32'h0,        32'h000000AA, 1'b0};
    vecs[9]  = '{1'b1, 5'd31, 32'h31313131, 1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h31313131, 32'h31313131, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd31, 5'd3,  32'h31313131, 32'h22222222, 1'b0};

    idle_inputs();
    reset = 1'b1;
    raddr = {5'd5, 5'd5};

    // Reset held for 3 edges.
    @(posedge clk); #1;
    check("reset_busy", busy, 1'b1);
    check("reset_wr_drop", wr_drop, 1'b0);
    check("reset_rdata", rdata, 64'h0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    count_busy(1'b1, cnt);
    check("busy_cycles_first", cnt, 32);
    check("busy_low_after_clear", busy, 1'b0);
    #1;
    check("dropped_write_not_stored", rdata, 64'h0);

    // Table-driven RUN vectors.
    for (int i = 0; i < 11; i++) begin
      we0 = vecs[i].we0; waddr0 = vecs[i].wa0; wdata0 = vecs[i].wd0;
      we1 = vecs[i].we1; waddr1 = vecs[i].wa1; wdata1 = vecs[i].wd1;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      $display("vec %0d: ra0=%0d rd0=%h ra1=%0d rd1=%h", i, vecs[i].ra0, rdata[31:0], vecs[i].ra1, rdata[63:32]);
      check($sformatf("vec%0d_rdata0", i), rdata[31:0], vecs[i].e0);
      check($sformatf("vec%0d_rdata1", i), rdata[63:32], vecs[i].e1);
      @(posedge clk); #1;
      check($sformatf("vec%0d_wr_drop", i), wr_drop, vecs[i].edrop);
      @(negedge clk);
    end
    idle_inputs();

    // Reset during RUN, then reset again at clear index 10.
    raddr = {5'd31, 5'd3};
    reset = 1'b1;
    @(posedge clk); #1;
    check("rerun_reset_busy", busy, 1'b1);
    check("rerun_reset_rdata", rdata, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midclear_still_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    count_busy(1'b0, cnt);
    check("busy_cycles_restart", cnt, 32);
    raddr = {5'd31, 5'd3};
    #1;
    $display("after re-clear: rd0=%h rd1=%h", rdata[31:0], rdata[63:32]);
    check("reclear_r3", rdata[31:0], 32'h0);
    check("reclear_r31", rdata[63:32], 32'h0);

    // Single traced write of $4 from PC 0x3004.
    @(negedge clk);
    we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h00004444; wpc0 = 32'h00003004;
    raddr = {5'd4, 5'd8};
    #1;
    check("trace_bypass_r4", rdata[63:32], 32'h00004444);
    check("trace_r8_cleared", rdata[31:0], 32'h0);
    @(posedge clk); #1;
    check("trace_wr_drop", wr_drop, 1'b0);
    @(negedge clk);
    idle_inputs();
    raddr = {5'd0, 5'd4};
    #1;
    $display("write $4: stored rd0=%h", rdata[31:0]);
    check("trace_stored_r4", rdata[31:0], 32'h00004444);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
